aexm_dcache: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache. It is the responder to the aexm core's data-memory control: dSTRLOD, dLOD, aexm_dcache_precycle_we and aexm_dcache_force_miss. It holds one-word lines and uses a one-entry posted write buffer. It drives a single-outstanding req/ack master port toward external memory and asserts dSTALL to freeze the core's pipeline enables.

---
 rtl/aexm_dcache_pkg.sv | 30 +++
 rtl/aexm_dcache_wbuf.sv | 48 ++++
 rtl/aexm_dcache.sv | 174 +++++++++++++++++
 tb/tb_aexm_dcache.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aexm_dcache_pkg.sv
// Shared types and helpers for the aexm data cache: FSM encoding, address
// field widths and the byte-lane merge used by stores.
package aexm_dcache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_WBWAIT = 2'd2,
        ST_DRAIN  = 2'd3
    } dc_state_t;

    function automatic int tag_width(input int aw, input int idx_w);
        return aw - 2 - idx_w;
    endfunction

    function automatic int line_count(input int idx_w);
        return 1 << idx_w;
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = sel[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/aexm_dcache_wbuf.sv
// One-entry posted write buffer; it requests the memory port while full and
// empties on the acknowledge of its own write.
module aexm_dcache_wbuf #(
    parameter int AW = 32
) (
    input  logic          gclk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [AW-3:0] push_adr_i,
    input  logic [31:0]   push_dat_i,
    input  logic [3:0]    push_sel_i,
    input  logic          grant_i,
    input  logic          ack_i,
    output logic          req_o,
    output logic          done_o,
    output logic [AW-3:0] adr_o,
    output logic [31:0]   dat_o,
    output logic [3:0]    sel_o
);
    logic          full_q;
    logic [AW-3:0] adr_q;
    logic [31:0]   dat_q;
    logic [3:0]    sel_q;

    assign req_o  = full_q;
    assign done_o = full_q & grant_i & ack_i;
    assign adr_o  = adr_q;
    assign dat_o  = dat_q;
    assign sel_o  = sel_q;

    // A push may land on the same edge the previous entry is acknowledged.
    always_ff @(posedge gclk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            adr_q  <= '0;
            dat_q  <= '0;
            sel_q  <= '0;
        end else if (push_i) begin
            full_q <= 1'b1;
            adr_q  <= push_adr_i;
            dat_q  <= push_dat_i;
            sel_q  <= push_sel_i;
        end else if (done_o) begin
            full_q <= 1'b0;
        end
    end

endmodule

// File: rtl/aexm_dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word
// lines, a posted write buffer and a single-outstanding memory master port.
module aexm_dcache
    import aexm_dcache_pkg::*;
#(
    parameter int IDX_W = 6,
    parameter int AW    = 32
) (
    input  logic          gclk,
    input  logic          rst_n,
    input  logic          d_en,
    input  logic          dSTRLOD,
    input  logic          dLOD,
    input  logic          aexm_dcache_precycle_we,
    input  logic          aexm_dcache_force_miss,
    input  logic [AW-1:0] xADR,
    input  logic [31:0]   xDAT,
    input  logic [3:0]    xSEL,
    output logic [31:0]   dDAT,
    output logic          dACK,
    output logic          dSTALL,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-3:0] mem_adr,
    output logic [31:0]   mem_dat_o,
    output logic [3:0]    mem_sel,
    input  logic          mem_ack,
    input  logic [31:0]   mem_dat_i
);
    localparam int TAG_W = tag_width(AW, IDX_W);
    localparam int LINES = line_count(IDX_W);

    dc_state_t     state_q;
    logic          stall_q, dack_q;
    logic [31:0]   ddat_q;
    logic [AW-3:0] req_adr_q;
    logic [31:0]   req_dat_q;
    logic [3:0]    req_sel_q;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    logic [AW-3:0]    lk_adr;
    logic [IDX_W-1:0] lk_idx, fill_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit, in_idle, in_fill, in_drain;
    logic             acc_ld, acc_st, ld_hit, ld_miss, st_post, st_block, fill_done;
    logic             push, wb_full, wb_done;
    logic [31:0]      push_dat, wb_dat;
    logic [3:0]       push_sel, wb_sel;
    logic [AW-3:0]    wb_adr;
    logic             unused_adr;

    assign unused_adr = ^xADR[1:0];

    assign in_idle  = (state_q == ST_IDLE);
    assign in_fill  = (state_q == ST_FILL);
    assign in_drain = (state_q == ST_DRAIN);

    // One lookup port: the core address in IDLE, the parked store while draining.
    assign lk_adr   = in_drain ? req_adr_q : xADR[AW-1:2];
    assign lk_idx   = lk_adr[IDX_W-1:0];
    assign lk_tag   = lk_adr[AW-3:IDX_W];
    assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign fill_idx = req_adr_q[IDX_W-1:0];

    assign acc_ld    = in_idle & d_en & dSTRLOD & dLOD;
    assign acc_st    = in_idle & d_en & dSTRLOD & ~dLOD & aexm_dcache_precycle_we;
    assign ld_hit    = acc_ld & lk_hit & ~aexm_dcache_force_miss;
    assign ld_miss   = acc_ld & ~ld_hit;
    assign st_post   = acc_st & (~wb_full | wb_done);
    assign st_block  = acc_st & ~st_post;
    assign fill_done = in_fill & mem_ack;

    assign push     = st_post | (in_drain & wb_done);
    assign push_dat = in_drain ? req_dat_q : xDAT;
    assign push_sel = in_drain ? req_sel_q : xSEL;

    assign dSTALL = stall_q | ld_miss | st_block;
    assign dACK   = dack_q;
    assign dDAT   = ddat_q;

    assign mem_req   = in_fill | wb_full;
    assign mem_we    = ~in_fill & wb_full;
    assign mem_adr   = in_fill ? req_adr_q : wb_adr;
    assign mem_dat_o = in_fill ? 32'h0 : wb_dat;
    assign mem_sel   = in_fill ? 4'hF : wb_sel;

    aexm_dcache_wbuf #(.AW(AW)) u_wbuf (
        .gclk       (gclk),
        .rst_n      (rst_n),
        .push_i     (push),
        .push_adr_i (lk_adr),
        .push_dat_i (push_dat),
        .push_sel_i (push_sel),
        .grant_i    (~in_fill),
        .ack_i      (mem_ack),
        .req_o      (wb_full),
        .done_o     (wb_done),
        .adr_o      (wb_adr),
        .dat_o      (wb_dat),
        .sel_o      (wb_sel)
    );

    always_ff @(posedge gclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            stall_q   <= 1'b0;
            dack_q    <= 1'b0;
            ddat_q    <= '0;
            req_adr_q <= '0;
            req_dat_q <= '0;
            req_sel_q <= '0;
        end else begin
            dack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (ld_hit) begin
                        dack_q <= 1'b1;
                        ddat_q <= data_q[lk_idx];
                    end else if (ld_miss) begin
                        req_adr_q <= lk_adr;
                        stall_q   <= 1'b1;
                        state_q   <= (wb_full && !wb_done) ? ST_WBWAIT : ST_FILL;
                    end else if (st_block) begin
                        req_adr_q <= lk_adr;
                        req_dat_q <= xDAT;
                        req_sel_q <= xSEL;
                        stall_q   <= 1'b1;
                        state_q   <= ST_DRAIN;
                    end
                end
                ST_WBWAIT: begin
                    if (wb_done) state_q <= ST_FILL;
                end
                ST_FILL: begin
                    if (mem_ack) begin
                        dack_q  <= 1'b1;
                        ddat_q  <= mem_dat_i;
                        stall_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (wb_done) begin
                        stall_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge gclk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (fill_done) begin
            valid_q[fill_idx] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; the valid bits alone qualify them.
    always_ff @(posedge gclk) begin
        if (fill_done) begin
            tag_q[fill_idx]  <= req_adr_q[AW-3:IDX_W];
            data_q[fill_idx] <= mem_dat_i;
        end else if (push && lk_hit) begin
            data_q[lk_idx] <= byte_merge(data_q[lk_idx], push_dat, push_sel);
        end
    end

endmodule

// File: tb/tb_aexm_dcache.sv
// Directed bench for aexm_dcache: a reference memory and line model predict
// load data and the ordered memory transactions; literals pin key cases.
module tb_aexm_dcache;

    typedef struct packed {
        logic        we;
        logic [29:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } txn_t;

    logic        gclk, rst_n;
    logic        d_en, dSTRLOD, dLOD, pwe, fmiss;
    logic [31:0] xADR, xDAT;
    logic [3:0]  xSEL;
    logic [31:0] dDAT;
    logic        dACK, dSTALL;
    logic        mem_req, mem_we, mem_ack;
    logic [29:0] mem_adr;
    logic [31:0] mem_dat_o, mem_dat_i;
    logic [3:0]  mem_sel;

    int n_chk = 0, n_pass = 0, n_txn = 0, ack_delay = 0;
    logic [31:0] ext_mem [logic [29:0]];
    logic [31:0] ref_mem [logic [29:0]];
    bit          mc_valid [64];
    logic [29:0] mc_word  [64];
    logic [31:0] mc_data  [64];
    logic [31:0] exp_q [$];
    txn_t        exp_txn [$];
    bit          txn_log [$];
    txn_t        last_txn;

    aexm_dcache #(.IDX_W(6), .AW(32)) dut (
        .gclk(gclk), .rst_n(rst_n), .d_en(d_en), .dSTRLOD(dSTRLOD), .dLOD(dLOD),
        .aexm_dcache_precycle_we(pwe), .aexm_dcache_force_miss(fmiss),
        .xADR(xADR), .xDAT(xDAT), .xSEL(xSEL), .dDAT(dDAT), .dACK(dACK),
        .dSTALL(dSTALL), .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr),
        .mem_dat_o(mem_dat_o), .mem_sel(mem_sel), .mem_ack(mem_ack),
        .mem_dat_i(mem_dat_i)
    );

    initial begin
        gclk = 1'b0;
        forever #5 gclk = ~gclk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, checks %0d/%0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    endtask

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                           input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (n & m) | (o & ~m);
    endfunction

    function automatic logic [31:0] ext_rd(input logic [29:0] a);
        return ext_mem.exists(a) ? ext_mem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [29:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    task automatic set_mem(input logic [29:0] a, input logic [31:0] v);
        ext_mem[a] = v;
        ref_mem[a] = v;
    endtask

    // Memory slave: acks after ack_delay cycles of a held request.
    initial begin
        int   wait_cnt;
        txn_t e;
        wait_cnt = 0;
        mem_ack = 1'b0;
        mem_dat_i = 32'h0;
        forever begin
            @(posedge gclk);
            #2;
            mem_ack = 1'b0;
            if (!rst_n || !mem_req) begin
                wait_cnt = 0;
            end else if (wait_cnt < ack_delay) begin
                wait_cnt++;
            end else begin
                wait_cnt = 0;
                mem_ack = 1'b1;
                last_txn = '{mem_we, mem_adr, mem_dat_o, mem_sel};
                chk("txn_pending", 64'(exp_txn.size() > 0), 64'd1);
                if (exp_txn.size() > 0) begin
                    e = exp_txn.pop_front();
                    chk("txn_we", 64'(mem_we), 64'(e.we));
                    chk("txn_adr", 64'(mem_adr), 64'(e.adr));
                    chk("txn_sel", 64'(mem_sel), 64'(e.sel));
                    if (e.we) chk("txn_dat", 64'(mem_dat_o), 64'(e.dat));
                end
                if (mem_we) ext_mem[mem_adr] = bmerge(ext_rd(mem_adr), mem_dat_o, mem_sel);
                else mem_dat_i = ext_rd(mem_adr);
                n_txn++;
                txn_log.push_back(mem_we);
                $display("txn %0d: we=%0d adr=0x%0h dat=0x%08h sel=%b", n_txn, mem_we,
                         mem_adr, mem_we ? mem_dat_o : mem_dat_i, mem_sel);
            end
        end
    end

    // Per-cycle compare: load data against the model, request held until ack.
    initial begin
        logic        p_req, p_ack;
        logic [29:0] p_adr;
        logic [36:0] p_rest;
        p_req = 1'b0; p_ack = 1'b0; p_adr = '0; p_rest = '0;
        forever begin
            @(negedge gclk);
            if (rst_n) begin
                if (dACK) begin
                    chk("dack_pending", 64'(exp_q.size() > 0), 64'd1);
                    if (exp_q.size() > 0) chk("ddat", 64'(dDAT), 64'(exp_q.pop_front()));
                end
                if (p_req && !p_ack) begin
                    chk("req_held", 64'(mem_req), 64'd1);
                    chk("req_adr_stable", 64'(mem_adr), 64'(p_adr));
                    chk("req_ctl_stable", 64'({mem_we, mem_dat_o, mem_sel}), 64'(p_rest));
                end
                p_req = mem_req;
                p_ack = mem_ack;
                p_adr = mem_adr;
                p_rest = {mem_we, mem_dat_o, mem_sel};
            end else begin
                p_req = 1'b0;
            end
        end
    end

    task automatic issue(input bit ld, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input bit fm, output bit stalled);
        logic [29:0] w;
        logic [5:0]  ix;
        @(negedge gclk);
        d_en = 1'b1; dSTRLOD = 1'b1; dLOD = ld; pwe = !ld; fmiss = fm;
        xADR = adr; xDAT = dat; xSEL = sel;
        #1 stalled = dSTALL;
        w = adr[31:2];
        ix = w[5:0];
        if (ld) begin
            if (mc_valid[ix] && mc_word[ix] == w && !fm) begin
                exp_q.push_back(mc_data[ix]);
            end else begin
                exp_q.push_back(ref_rd(w));
                exp_txn.push_back('{1'b0, w, 32'h0, 4'hF});
                mc_valid[ix] = 1'b1;
                mc_word[ix] = w;
                mc_data[ix] = ref_rd(w);
            end
        end else begin
            ref_mem[w] = bmerge(ref_rd(w), dat, sel);
            if (mc_valid[ix] && mc_word[ix] == w) mc_data[ix] = bmerge(mc_data[ix], dat, sel);
            exp_txn.push_back('{1'b1, w, dat, sel});
        end
        @(posedge gclk);
        #1;
        d_en = 1'b0; dSTRLOD = 1'b0; dLOD = 1'b0; pwe = 1'b0; fmiss = 1'b0;
    endtask

    task automatic wait_ack(output logic [31:0] d, output int lat);
        lat = 0;
        while (!dACK && lat < 100) begin
            @(posedge gclk);
            #1;
            lat++;
        end
        chk("ack_seen", 64'(dACK), 64'd1);
        d = dDAT;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((dSTALL || mem_req) && n < 100) begin
            @(posedge gclk);
            #1;
            n++;
        end
        chk("idle_reached", 64'(dSTALL | mem_req), 64'd0);
    endtask

    initial begin
        bit          st;
        logic [31:0] d;
        int          lat, n0, n;

        rst_n = 1'b0; d_en = 1'b0; dSTRLOD = 1'b0; dLOD = 1'b0; pwe = 1'b0;
        fmiss = 1'b0; xADR = '0; xDAT = '0; xSEL = '0;
        repeat (3) @(negedge gclk);
        chk("rst_dstall", 64'(dSTALL), 64'd0);
        chk("rst_dack", 64'(dACK), 64'd0);
        chk("rst_ddat", 64'(dDAT), 64'd0);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_adr", 64'(mem_adr), 64'd0);
        chk("rst_mem_dat", 64'(mem_dat_o), 64'd0);
        chk("rst_mem_sel", 64'(mem_sel), 64'd0);
        rst_n = 1'b1;

        // Cold load, then a hit on the same word.
        ack_delay = 2;
        set_mem(30'h40, 32'hDEADBEEF);
        issue(1'b1, 32'h100, 32'h0, 4'h0, 1'b0, st);
        chk("cold_stall", 64'(st), 64'd1);
        wait_ack(d, lat);
        chk("cold_data", 64'(d), 64'hDEADBEEF);
        chk("cold_rd_adr", 64'(last_txn.adr), 64'h40);
        chk("cold_rd_we", 64'(last_txn.we), 64'd0);
        chk("cold_rd_sel", 64'(last_txn.sel), 64'hF);
        n0 = n_txn;
        issue(1'b1, 32'h100, 32'h0, 4'h0, 1'b0, st);
        chk("hit_stall", 64'(st), 64'd0);
        wait_ack(d, lat);
        chk("hit_latency", 64'(lat), 64'd0);
        chk("hit_data", 64'(d), 64'hDEADBEEF);
        chk("hit_no_txn", 64'(n_txn), 64'(n0));

        // Partial store to a cached word, re-read while still posted.
        issue(1'b0, 32'h100, 32'hAABBCCDD, 4'b0011, 1'b0, st);
        chk("st_stall", 64'(st), 64'd0);
        issue(1'b1, 32'h100, 32'h0, 4'h0, 1'b0, st);
        wait_ack(d, lat);
        chk("raw_latency", 64'(lat), 64'd0);
        chk("raw_data", 64'(d), 64'hDEADCCDD);
        wait_idle();
        chk("st_txn_count", 64'(n_txn), 64'(n0 + 1));
        chk("st_wr_sel", 64'(last_txn.sel), 64'b0011);
        chk("st_wr_dat", 64'(last_txn.dat), 64'hAABBCCDD);
        chk("st_wr_we", 64'(last_txn.we), 64'd1);

        // Back-to-back stores with a slow memory.
        ack_delay = 5;
        n0 = n_txn;
        issue(1'b0, 32'h200, 32'h11112222, 4'hF, 1'b0, st);
        chk("b2b_first_stall", 64'(st), 64'd0);
        issue(1'b0, 32'h204, 32'h33334444, 4'hF, 1'b0, st);
        chk("b2b_second_stall", 64'(st), 64'd1);
        n = 0;
        while (dSTALL && n < 100) begin
            @(posedge gclk);
            #1;
            n++;
        end
        chk("b2b_release_after_ack", 64'(n_txn), 64'(n0 + 1));
        wait_idle();
        chk("b2b_both_written", 64'(n_txn), 64'(n0 + 2));
        issue(1'b1, 32'h204, 32'h0, 4'h0, 1'b0, st);
        chk("no_alloc_miss", 64'(st), 64'd1);
        wait_ack(d, lat);
        chk("no_alloc_data", 64'(d), 64'h33334444);

        // Forced refetch of a resident line after memory changed underneath.
        ack_delay = 1;
        set_mem(30'h40, 32'h12345678);
        issue(1'b1, 32'h100, 32'h0, 4'h0, 1'b1, st);
        chk("fm_stall", 64'(st), 64'd1);
        wait_ack(d, lat);
        chk("fm_data", 64'(d), 64'h12345678);

        // Ignored requests: d_en low, and a store without precycle_we.
        n0 = n_txn;
        @(negedge gclk);
        d_en = 1'b0; dSTRLOD = 1'b1; dLOD = 1'b1; xADR = 32'h100;
        #1 chk("ign_den_stall", 64'(dSTALL), 64'd0);
        @(negedge gclk);
        d_en = 1'b1; dSTRLOD = 1'b1; dLOD = 1'b0; pwe = 1'b0;
        xADR = 32'h100; xDAT = 32'hFFFFFFFF; xSEL = 4'hF;
        #1 chk("ign_nowe_stall", 64'(dSTALL), 64'd0);
        @(negedge gclk);
        d_en = 1'b0; dSTRLOD = 1'b0;
        repeat (3) @(negedge gclk);
        chk("ign_no_txn", 64'(n_txn), 64'(n0));
        issue(1'b1, 32'h100, 32'h0, 4'h0, 1'b0, st);
        wait_ack(d, lat);
        chk("fm_line_updated", 64'(d), 64'h12345678);
        chk("fm_hit_latency", 64'(lat), 64'd0);

        // Load miss behind a posted write to the same word: drain, then fill.
        ack_delay = 3;
        issue(1'b0, 32'h500, 32'h0BADF00D, 4'hF, 1'b0, st);
        issue(1'b1, 32'h500, 32'h0, 4'h0, 1'b0, st);
        chk("wbmiss_stall", 64'(st), 64'd1);
        wait_ack(d, lat);
        chk("wbmiss_data", 64'(d), 64'h0BADF00D);
        chk("wbmiss_order_wr", 64'(txn_log[txn_log.size()-2]), 64'd1);
        chk("wbmiss_order_rd", 64'(txn_log[txn_log.size()-1]), 64'd0);
        issue(1'b1, 32'h100, 32'h0, 4'h0, 1'b0, st);
        chk("evicted_miss", 64'(st), 64'd1);
        wait_ack(d, lat);
        chk("evicted_data", 64'(d), 64'h12345678);

        // Reset in the middle of a fill.
        ack_delay = 20;
        set_mem(30'h1C0, 32'h77770000);
        issue(1'b1, 32'h700, 32'h0, 4'h0, 1'b0, st);
        repeat (3) begin
            @(posedge gclk);
            #1;
        end
        chk("fill_req_up", 64'(mem_req), 64'd1);
        @(negedge gclk);
        rst_n = 1'b0;
        exp_q.delete();
        exp_txn.delete();
        foreach (mc_valid[i]) mc_valid[i] = 1'b0;
        #1;
        chk("rst_fill_req_drop", 64'(mem_req), 64'd0);
        chk("rst_fill_stall_drop", 64'(dSTALL), 64'd0);
        repeat (2) @(negedge gclk);
        rst_n = 1'b1;
        ack_delay = 1;
        issue(1'b1, 32'h700, 32'h0, 4'h0, 1'b0, st);
        chk("post_rst_miss", 64'(st), 64'd1);
        wait_ack(d, lat);
        chk("post_rst_data", 64'(d), 64'h77770000);
        issue(1'b1, 32'h100, 32'h0, 4'h0, 1'b0, st);
        chk("post_rst_invalid", 64'(st), 64'd1);
        wait_ack(d, lat);
        wait_idle();

        repeat (2) @(negedge gclk);
        chk("loads_drained", 64'(exp_q.size()), 64'd0);
        chk("txns_drained", 64'(exp_txn.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
